// File: rtl/shift_deser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_deser_pkg
// Purpose  : Shared defaults and types for the serial-to-parallel deserializer.
// Revision : 1.0 - initial release
// ============================================================================
package shift_deser_pkg;

  localparam int C_DEFAULT_WIDTH         = 16;
  localparam int C_DEFAULT_WORDS_PER_PKT = 82;
  localparam int C_OVF_CNT_W             = 8;

  typedef logic [C_OVF_CNT_W-1:0] ovf_count_t;

  localparam ovf_count_t C_OVF_CNT_MAX = '1;

endpackage
`default_nettype wire

// File: rtl/shift_deser_sipo.sv
`default_nettype none
// ============================================================================
// Module   : shift_deser_sipo
// Purpose  : Serial-in/parallel-out bit assembler with selectable bit order.
// Revision : 1.0 - initial release
// ============================================================================
module shift_deser_sipo
  import shift_deser_pkg::*;
#(
  parameter int WIDTH     = C_DEFAULT_WIDTH,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             i_shift,
  input  logic             i_clear,
  input  logic             i_data,
  output logic             o_complete,
  output logic [WIDTH-1:0] o_word
);

  localparam int                 C_CNT_W    = $clog2(WIDTH);
  localparam logic [C_CNT_W-1:0] C_LAST_BIT = C_CNT_W'(WIDTH - 1);

  // Only WIDTH-1 bits need storing: the final bit is taken straight from i_data.
  logic [WIDTH-2:0]   r_partial;
  logic [C_CNT_W-1:0] r_count;
  logic [WIDTH-1:0]   w_word;
  logic [WIDTH-2:0]   w_partial_next;
  logic               w_accept;

  assign w_accept   = i_shift & ~i_clear;
  assign o_complete = w_accept & (r_count == C_LAST_BIT);
  assign o_word     = w_word;

  generate
    if (LSB_FIRST != 0) begin : g_lsb_first
      assign w_word         = {i_data, r_partial};
      assign w_partial_next = w_word[WIDTH-1:1];
    end else begin : g_msb_first
      assign w_word         = {r_partial, i_data};
      assign w_partial_next = w_word[WIDTH-2:0];
    end
  endgenerate

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_partial <= '0;
      r_count   <= '0;
    end else if (i_clear) begin
      r_partial <= '0;
      r_count   <= '0;
    end else if (w_accept) begin
      if (o_complete) begin
        r_partial <= '0;
        r_count   <= '0;
      end else begin
        r_partial <= w_partial_next;
        r_count   <= r_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/shift_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : shift_deserializer
// Purpose  : Serial bit stream to word stream with valid/ready hand-off,
//            packet framing (last_o) and overflow detection.
//            Optional SHIFT_DESER_OVF_CNT_EN adds a saturating ovf_count_o.
// Revision : 1.0 - initial release
// ============================================================================
module shift_deserializer
  import shift_deser_pkg::*;
#(
  parameter int width_p         = C_DEFAULT_WIDTH,
  parameter int lsb_first_p     = 0,
  parameter int words_per_pkt_p = C_DEFAULT_WORDS_PER_PKT
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               data_i,
  input  logic               shift_i,
  input  logic               clear_i,
  output logic [width_p-1:0] data_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               last_o,
  output logic               overflow_o
`ifdef SHIFT_DESER_OVF_CNT_EN
  ,
  output ovf_count_t         ovf_count_o
`endif
);

  generate
    if (width_p < 2) begin : g_bad_width
      $error("shift_deserializer: width_p must be >= 2");
    end
    if (words_per_pkt_p < 1) begin : g_bad_words
      $error("shift_deserializer: words_per_pkt_p must be >= 1");
    end
  endgenerate

  localparam int                 C_IDX_W    = (words_per_pkt_p > 1) ? $clog2(words_per_pkt_p) : 1;
  localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(words_per_pkt_p - 1);

  logic               w_complete;
  logic [width_p-1:0] w_word;
  logic               w_slot_free;
  logic               w_idx_is_last;

  logic [width_p-1:0] r_data;
  logic               r_valid;
  logic               r_last;
  logic               r_overflow;
  logic [C_IDX_W-1:0] r_word_idx;

  shift_deser_sipo #(
    .WIDTH     (width_p),
    .LSB_FIRST (lsb_first_p)
  ) u_sipo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .i_shift    (shift_i),
    .i_clear    (clear_i),
    .i_data     (data_i),
    .o_complete (w_complete),
    .o_word     (w_word)
  );

  assign w_slot_free   = ~r_valid | ready_i;
  assign w_idx_is_last = (r_word_idx == C_LAST_IDX);

  // Dropped words still consume an index so framing stays aligned to the stream.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_word_idx <= '0;
    end else if (clear_i) begin
      r_word_idx <= '0;
    end else if (w_complete) begin
      r_word_idx <= w_idx_is_last ? '0 : r_word_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      if (w_complete) begin
        if (w_slot_free) begin
          r_data  <= w_word;
          r_last  <= w_idx_is_last;
          r_valid <= 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef SHIFT_DESER_OVF_CNT_EN
  ovf_count_t r_ovf_count;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_ovf_count <= '0;
    end else if (w_complete && !w_slot_free && (r_ovf_count != C_OVF_CNT_MAX)) begin
      r_ovf_count <= r_ovf_count + 1'b1;
    end
  end

  assign ovf_count_o = r_ovf_count;
`endif

  assign data_o     = r_data;
  assign valid_o    = r_valid;
  assign last_o     = r_last;
  assign overflow_o = r_overflow;

endmodule
`default_nettype wire
